// File: rtl/square_i2s.sv
// square_i2s: square-wave test-tone generator streaming 16-bit stereo I2S.
// A free-running 9-bit divider supplies MCLK/SCLK/LRCLK; once per frame the
// tone phase is advanced and the next sample is latched. The same sample
// is sent on both channels, MSB first, one bit clock after each word-select edge.
module square_i2s #(
  parameter logic signed [15:0] AMPLITUDE = 16'sh2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period,
  output logic        mclk,
  output logic        lrclk,
  output logic        sdin,
  output logic        sclk
);

  logic [8:0]  div;
  logic [15:0] hp;
  logic        phase;
  logic [15:0] sample;
  logic [31:0] word;
  logic        frame_start;
  logic        sclk_fall;
  logic [4:0]  bit_idx;
  logic        next_phase;
  logic [15:0] next_hp;

  // The divider is 511 on the last clk of a frame, so that edge starts the next frame.
  assign frame_start = (div == 9'd511);
  // Bit-clock low phase begins when the low nibble wraps 15 -> 0.
  assign sclk_fall   = (div[3:0] == 4'hF);

  // Both channels carry the same sample.
  assign word = {sample, sample};

  // The slot about to start is div[8:4]+1 and carries word bit (32 - slot) mod 32,
  // which reduces to the bitwise inverse of the current slot number. When the next
  // slot is 0 this selects bit 0 of the word still held, i.e. the previous frame's
  // right-channel LSB.
  assign bit_idx = ~div[8:4];

  // Clocks are plain divider bits, so they are glitch-free register outputs.
  assign mclk  = div[1];
  assign sclk  = div[3];
  assign lrclk = div[8];

  // Free-running frame divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= 9'd0;
    end else begin
      div <= div + 9'd1;
    end
  end

  // Next half-period count and phase; a zero period freezes the tone.
  always_comb begin
    next_phase = phase;
    next_hp    = hp;
    if (period != 16'd0) begin
      if (hp >= period - 16'd1) begin
        next_hp    = 16'd0;
        next_phase = ~phase;
      end else begin
        next_hp = hp + 16'd1;
      end
    end
  end

  // Advance the tone and latch this frame's sample only at frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hp     <= 16'd0;
      phase  <= 1'b1;
      sample <= 16'd0;
    end else if (frame_start) begin
      hp     <= next_hp;
      phase  <= next_phase;
      sample <= next_phase ? AMPLITUDE : -AMPLITUDE;
    end
  end

  // Serial data changes only as the bit clock falls, keeping it stable across rising edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sdin <= 1'b0;
    end else if (sclk_fall) begin
      sdin <= word[bit_idx];
    end
  end

endmodule

// File: tb/tb_square_i2s.sv
// tb_square_i2s: self-checking bench for square_i2s. A reference divider and
// tone model push the expected sample per channel into a scoreboard queue; an
// I2S decoder rebuilds words from sdin on SCLK rising edges and compares them.
module tb_square_i2s;

  logic        clk;
  logic        reset;
  logic [15:0] period;
  logic        mclk;
  logic        lrclk;
  logic        sdin;
  logic        sclk;

  int checks;
  int errors;
  int decoded;

  // Reference model state
  logic [8:0]  mdiv;
  int          mhp;
  logic        mphase;
  logic [15:0] expQ[$];

  // Decoder state
  logic        prevSclk;
  logic        prevLr;
  logic [15:0] sr;
  logic        prevSdin;

  localparam logic [15:0] POS = 16'h2000;
  localparam logic [15:0] NEG = 16'hE000;

  square_i2s dut (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .mclk   (mclk),
    .lrclk  (lrclk),
    .sdin   (sdin),
    .sclk   (sclk)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] newPeriod, input int cycles);
    @(negedge clk);
    period = newPeriod;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference divider and tone model; pushes expected left/right words each frame.
  always @(posedge clk or negedge reset) begin
    logic nPhase;
    if (!reset) begin
      mdiv   <= 9'd0;
      mhp    <= 0;
      mphase <= 1'b1;
      expQ.delete();
      expQ.push_back(16'h0000);
      expQ.push_back(16'h0000);
    end else begin
      mdiv <= mdiv + 9'd1;
      if (mdiv == 9'd511) begin
        nPhase = mphase;
        if (period == 16'd0) begin
          nPhase = mphase;
        end else if (mhp + 1 >= int'(period)) begin
          mhp    <= 0;
          nPhase = ~mphase;
        end else begin
          mhp <= mhp + 1;
        end
        mphase <= nPhase;
        expQ.push_back(nPhase ? POS : NEG);
        expQ.push_back(nPhase ? POS : NEG);
      end
    end
  end

  // Clock outputs and sdin timing are checked every cycle on the falling clk edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("resetOutputs", {28'd0, mclk, sclk, lrclk, sdin}, 32'd0);
      prevSdin <= 1'b0;
    end else begin
      checkOutput("clocks", {29'd0, mclk, sclk, lrclk},
                  {29'd0, mdiv[1], mdiv[3], mdiv[8]});
      if (sdin !== prevSdin) begin
        checkOutput("sdinEdge", {28'd0, mdiv[3:0]}, 32'd0);
      end
      prevSdin <= sdin;
    end
  end

  // I2S decoder: a word ends on the first SCLK rise after LRCLK changes.
  always @(negedge clk) begin
    logic [15:0] w;
    logic [15:0] e;
    if (!reset) begin
      prevSclk <= 1'b0;
      prevLr   <= 1'b0;
      sr       <= 16'd0;
    end else begin
      if (sclk && !prevSclk) begin
        w = {sr[14:0], sdin};
        sr <= w;
        if (lrclk !== prevLr) begin
          decoded++;
          if (expQ.size() == 0) begin
            checkOutput("queueEmpty", 32'd0, 32'd1);
          end else begin
            e = expQ.pop_front();
            checkOutput(prevLr ? "rightWord" : "leftWord", {16'd0, w}, {16'd0, e});
          end
        end
        prevLr <= lrclk;
      end
      prevSclk <= sclk;
    end
  end

  // Directed sequence: reset, period 2, mid-frame change to 5, async reset, period 0.
  initial begin
    checks   = 0;
    errors   = 0;
    decoded  = 0;
    prevSdin = 1'b0;
    reset    = 1'b0;
    period   = 16'd2;
    repeat (512) @(negedge clk);
    reset = 1'b1;

    $display("[TB] period=2 run");
    applyStimulus(16'd2, 8 * 512);
    applyStimulus(16'd2, 200);

    $display("[TB] period change 2->5 mid-frame");
    applyStimulus(16'd5, 12 * 512);

    $display("[TB] asynchronous reset mid-frame");
    repeat (300) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("asyncMclk", {31'd0, mclk}, 32'd0);
    checkOutput("asyncSclk", {31'd0, sclk}, 32'd0);
    checkOutput("asyncLrclk", {31'd0, lrclk}, 32'd0);
    checkOutput("asyncSdin", {31'd0, sdin}, 32'd0);
    repeat (20) @(negedge clk);
    period = 16'd0;
    reset  = 1'b1;

    $display("[TB] period=0 run");
    applyStimulus(16'd0, 9 * 512);

    checkOutput("decodeCount", {31'd0, decoded >= 50}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
